// File: rtl/rv32c_prefetch_queue.sv
// Sequential word prefetcher feeding the RV32C fetch buffer, with redirect/drain handling.
// Optional performance counters are enabled by defining RV32C_PREFETCH_PERF_EN.
module rv32c_prefetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        nrst,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic        imem_busy,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [31:0] word_addr,
    input  logic        word_ready
`ifdef RV32C_PREFETCH_PERF_EN
    ,
    output logic [31:0] perf_discard_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        FETCH,
        DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   head_q, tail_q;
    logic [31:0]     fetch_pc_q;
    logic [31:0]     drain_addr_q;
    logic [31:0]     data_mem [DEPTH];
    logic [31:0]     addr_mem [DEPTH];

    logic            complete;
    logic            push;
    logic            pop;
    logic            unused_pc_bits;

    // The halfword offset is resolved downstream from word_addr versus its own PC.
    assign unused_pc_bits = |redirect_pc[1:0];

    always_comb begin
        state_d   = state_q;
        imem_ren  = 1'b0;
        imem_addr = fetch_pc_q;
        unique case (state_q)
            FETCH: begin
                imem_ren = nrst && (count_q < DEPTH_C);
                if (redirect && imem_ren && imem_busy) state_d = DRAIN;
            end
            DRAIN: begin
                imem_ren  = nrst;
                imem_addr = drain_addr_q;
                if (nrst && !imem_busy) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    assign complete   = imem_ren && !imem_busy;
    assign word_valid = nrst && (state_q == FETCH) && (count_q != '0);
    assign push       = complete && (state_q == FETCH) && !redirect;
    assign pop        = word_valid && word_ready && !redirect;
    assign word       = data_mem[head_q];
    assign word_addr  = addr_mem[head_q];

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= FETCH;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (redirect) begin
                count_q    <= '0;
                head_q     <= '0;
                tail_q     <= '0;
                fetch_pc_q <= {redirect_pc[31:2], 2'b00};
            end else begin
                if (push) begin
                    tail_q     <= tail_q + PW'(1);
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                if (pop) head_q <= head_q + PW'(1);
                unique case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (state_q == FETCH && state_d == DRAIN) drain_addr_q <= fetch_pc_q;
        if (push) begin
            data_mem[tail_q] <= imem_rdata;
            addr_mem[tail_q] <= fetch_pc_q;
        end
    end

`ifdef RV32C_PREFETCH_PERF_EN
    logic discard;
    logic stall;

    assign discard = complete && ((state_q == DRAIN) || redirect);
    assign stall   = imem_ren && imem_busy;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            perf_discard_cnt <= '0;
            perf_stall_cnt   <= '0;
        end else begin
            if (discard && perf_discard_cnt != 32'hFFFF_FFFF)
                perf_discard_cnt <= perf_discard_cnt + 32'd1;
            if (stall && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
